// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM with memory handshake, timeout fault and illegal-op detection.
// Define JUMP_EN to add the j instruction (JUMP state); otherwise opcode 000010 is illegal.
module multicycle_controller #(
  parameter int ALUC_W = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              IorD,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic              Branch,
  output logic              PCWrite,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [1:0]        PCSrc,
  output logic              illegal,
  output logic              fault,
  output logic [3:0]        state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
                         MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
                         ADDIWB = 4'd10, JUMP = 4'd11, FAULT = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
`ifdef JUMP_EN
  localparam bit HAS_JUMP = 1'b1;
`else
  localparam bit HAS_JUMP = 1'b0;
`endif
  logic [3:0] nxt, dec_nxt, fcode, alu;
  logic [TO_W-1:0] cnt;
  logic mreq, to_hit, r_ok, zero_unused;
  // zero only feeds the datapath's PCEn; the FSM itself never branches on it
  assign zero_unused = zero;
  assign r_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
  assign fcode = funct == 6'b100010 ? 4'b0001 :
                 funct == 6'b100100 ? 4'b1000 :
                 funct == 6'b100101 ? 4'b1001 :
                 funct == 6'b100110 ? 4'b1010 :
                 funct == 6'b100111 ? 4'b1011 : 4'b0000;
  assign dec_nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                   (opcode == OP_R && r_ok)             ? EXEC   :
                   opcode == OP_BEQ                     ? BRANCH :
                   opcode == OP_ADDI                    ? ADDIEX :
                   (HAS_JUMP && opcode == OP_J)         ? JUMP   : FETCH;
  assign mreq = state == FETCH || state == MEMRD || state == MEMWR;
  // ready on the final allowed cycle takes priority over the timeout
  assign to_hit = mreq && !mem_ready && cnt == TO_W'(MEM_TIMEOUT - 1);
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : to_hit ? FAULT : FETCH;
      DECODE: nxt = dec_nxt;
      MEMADR: nxt = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : to_hit ? FAULT : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : to_hit ? FAULT : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      FAULT:  nxt = FAULT;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : (mreq && !mem_ready) ? cnt + 1'b1 : cnt;
    end
  assign alu        = state == EXEC ? fcode : state == BRANCH ? 4'b0001 : 4'b0000;
  assign ALUControl = ALUC_W'(alu);
  assign mem_req    = mreq && !reset;
  assign IorD       = state == MEMRD || state == MEMWR;
  assign MemWrite   = state == MEMWR && !reset;
  assign IRWrite    = state == FETCH && mem_ready && !reset;
  assign PCWrite    = ((state == FETCH && mem_ready) || (HAS_JUMP && state == JUMP)) && !reset;
  assign RegDst     = state == ALUWB;
  assign MemtoReg   = state == MEMWB;
  assign RegWrite   = (state == MEMWB || state == ALUWB || state == ADDIWB) && !reset;
  assign ALUSrcA    = state == MEMADR || state == EXEC || state == BRANCH || state == ADDIEX;
  assign Branch     = state == BRANCH && !reset;
  assign ALUSrcB    = state == DECODE ? 2'b11 : (state == MEMADR || state == ADDIEX) ? 2'b10 :
                      state == FETCH ? 2'b01 : 2'b00;
  assign PCSrc      = state == BRANCH ? 2'b01 : (HAS_JUMP && state == JUMP) ? 2'b10 : 2'b00;
  assign illegal    = state == DECODE && dec_nxt == FETCH;
  assign fault      = state == FAULT;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked against a per-instruction phase model.
module tb_multicycle_controller;
  localparam int TMO = 4;
`ifdef JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  typedef struct packed {
    logic mr, iod, mw, irw, rd, m2r, rw, sa, br, pw;
    logic [1:0] sb; logic [3:0] ac; logic [1:0] ps; logic il, f; logic [3:0] st;
  } outs_t;
  typedef struct packed { logic [3:0] st; logic rdy; } step_t;
  logic clk = 0, reset = 1, zero = 0, mem_ready = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl, state;
  logic illegal, fault;
  outs_t dut_o;
  step_t cur, q[$];
  outs_t seen[$];
  bit chk_en = 0;
  int errors = 0, checks = 0;
  multicycle_controller #(.ALUC_W(4), .MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .illegal(illegal), .fault(fault), .state(state));
  assign dut_o = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite,
                  ALUSrcB, ALUControl, PCSrc, illegal, fault, state};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    logic [3:0] tbl [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    return tbl[fn[2:0]];
  endfunction
  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    return op inside {LW, SW, BEQ, ADDI} || (JEN && op == J) ||
           (op == 6'b0 && fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111});
  endfunction
  // Expected outputs of one cycle, from the per-phase control table
  function automatic outs_t model(input logic [3:0] s, input logic r, input logic [5:0] op, input logic [5:0] fn);
    outs_t o = '0;
    o.st = s;
    case (s)
      0:  begin o.mr = 1; o.sb = 2'b01; o.irw = r; o.pw = r; end
      1:  begin o.sb = 2'b11; o.il = !legal(op, fn); end
      2, 9: begin o.sa = 1; o.sb = 2'b10; end
      3:  begin o.mr = 1; o.iod = 1; end
      4:  begin o.m2r = 1; o.rw = 1; end
      5:  begin o.mr = 1; o.iod = 1; o.mw = 1; end
      6:  begin o.sa = 1; o.ac = alu_of(fn); end
      7:  begin o.rd = 1; o.rw = 1; end
      8:  begin o.sa = 1; o.ac = 4'b0001; o.br = 1; o.ps = 2'b01; end
      10: o.rw = 1;
      11: begin o.ps = 2'b10; o.pw = 1; end
      15: o.f = 1;
      default: ;
    endcase
    return o;
  endfunction
  always @(negedge clk)
    if (chk_en) begin
      chk($sformatf("cycle st=%0d op=%b", cur.st, opcode), dut_o, model(cur.st, cur.rdy, opcode, funct));
      seen.push_back(dut_o);
    end
  task automatic run_q;
    while (q.size() > 0) begin
      cur = q.pop_front();
      mem_ready = cur.rdy;
      chk_en = 1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask
  // A memory access: lat not-ready cycles, then ready unless the timeout fires first
  task automatic wait_mem(input logic [3:0] st, input int lat, output bit flt);
    flt = lat >= TMO;
    for (int i = 0; i < lat && i < TMO; i++) q.push_back('{st, 1'b0});
    if (flt) repeat (3) q.push_back('{4'd15, 1'b0});
    else q.push_back('{st, 1'b1});
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int flat, input int mlat, output int b);
    bit flt;
    b = seen.size();
    q.delete();
    opcode = op;
    funct = fn;
    wait_mem(0, flat, flt);
    if (!flt) begin
      q.push_back('{4'd1, 1'b0});
      if (op == LW) begin
        q.push_back('{4'd2, 1'b0});
        wait_mem(3, mlat, flt);
        if (!flt) q.push_back('{4'd4, 1'b0});
      end else if (op == SW) begin
        q.push_back('{4'd2, 1'b0});
        wait_mem(5, mlat, flt);
      end else if (legal(op, fn) && op == 6'b0) begin
        q.push_back('{4'd6, 1'b0}); q.push_back('{4'd7, 1'b0});
      end else if (op == BEQ) q.push_back('{4'd8, 1'b0});
      else if (op == ADDI) begin
        q.push_back('{4'd9, 1'b0}); q.push_back('{4'd10, 1'b0});
      end else if (JEN && op == J) q.push_back('{4'd11, 1'b0});
    end
    run_q();
  endtask
  task automatic rst_seq;
    chk_en = 0;
    reset = 1;
    mem_ready = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_enables", {MemWrite, IRWrite, RegWrite, PCWrite, Branch}, 0);
    chk("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_wr", {PCWrite, IRWrite}, 0);
    chk("post_rst_fault", fault, 0);
  endtask
  initial begin
    int b, n;
    rst_seq();
    instr(LW, 0, 0, 0, b);
    chk("lw_wb_state", seen[b+4].st, 4);
    chk("lw_wb_rw_m2r", {seen[b+4].rw, seen[b+4].m2r}, 2'b11);
    n = 0;
    for (int i = 0; i < 5; i++) n += int'(seen[b+i].rw);
    chk("lw_rw_count", n, 1);
    instr(0, 6'b100110, 0, 0, b);
    chk("xor_alu", seen[b+2].ac, 4'b1010);
    chk("xor_wb", {seen[b+3].rd, seen[b+3].rw}, 2'b11);
    zero = 1;
    instr(BEQ, 0, 0, 0, b);
    chk("beq_ctl", {seen[b+2].br, seen[b+2].ps, seen[b+2].ac}, {1'b1, 2'b01, 4'b0001});
    zero = 0;
    instr(LW, 0, 2, 3, b);
    instr(SW, 0, 1, TMO - 1, b);
    chk("sw_ready_at_limit", seen[b+TMO+5].st, 0);
    instr(ADDI, 0, 0, 0, b);
    foreach (funct_list[i]) instr(0, funct_list[i], 0, 0, b);
    instr(0, 6'b001000, 0, 0, b);
    chk("bad_funct_illegal", seen[b+1].il, 1);
    instr(J, 0, 0, 0, b);
    if (JEN) chk("j_ctl", {seen[b+2].ps, seen[b+2].pw}, {2'b10, 1'b1});
    else chk("j_illegal", {seen[b+1].il, seen[b+2].st}, {1'b1, 4'd0});
    instr(6'b111111, 0, 0, 0, b);
    instr(SW, 0, 0, 99, b);
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(seen[b+i].mw);
    chk("sw_timeout_mw_cycles", n, TMO);
    chk("fault_sticky", {seen[b+9].st, seen[b+9].f}, {4'd15, 1'b1});
    rst_seq();
    instr(LW, 0, 99, 0, b);
    chk("fetch_timeout", seen[b+TMO].st, 15);
    rst_seq();
    q.delete();
    opcode = SW;
    q.push_back('{4'd0, 1'b1}); q.push_back('{4'd1, 1'b0});
    q.push_back('{4'd2, 1'b0}); q.push_back('{4'd5, 1'b0});
    run_q();
    chk("pre_async_state", state, 5);
    reset = 1;
    #1;
    chk("async_drop", {mem_req, MemWrite}, 0);
    rst_seq();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  logic [5:0] funct_list [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111};
endmodule
